// File: rtl/command_receiver.sv
// command_receiver: parses framed UART command packets (SYNC CMD LEN PAYLOAD CHK) into one-cycle command strobes.
// Optional inter-byte timeout is built when CMD_RX_TIMEOUT_EN is defined.
module command_receiver #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         MAX_PAYLOAD    = 4,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_start,
  output logic       cmd_difficulty_valid,
  output logic       difficulty,
  output logic       cmd_move_valid,
  output logic [1:0] move_dir,
  output logic       cmd_number_valid,
  output logic [3:0] number,
  output logic       cmd_place,
  output logic       cmd_restart,
  output logic       frame_error,
  output logic [1:0] error_code,
  output logic [7:0] error_count
);
  typedef enum logic [2:0] {S_SYNC, S_CMD, S_LEN, S_PAY, S_CHK} state_t;
  state_t     state;
  logic [7:0] cmd, acc, pay0;
  logic [3:0] len, idx;
  logic       cmd_ok, chk_ok, accept, reject, timeout_hit;
  logic [1:0] reject_code;
  assign cmd_ok = (cmd == 8'h01 || cmd == 8'h05 || cmd == 8'h06) ? len == 4'd0 :
                  (cmd == 8'h02 || cmd == 8'h03) ? len == 4'd1 :
                  (cmd == 8'h04) ? (len == 4'd1 && pay0 >= 8'd1 && pay0 <= 8'd9) : 1'b0;
  assign chk_ok = rx_data == acc;
  assign accept = rx_valid && state == S_CHK && chk_ok && cmd_ok;
  assign reject = timeout_hit ||
                  (rx_valid && state == S_LEN && rx_data > 8'(MAX_PAYLOAD)) ||
                  (rx_valid && state == S_CHK && !(chk_ok && cmd_ok));
  assign reject_code = timeout_hit ? 2'b11 : state == S_LEN ? 2'b00 : !chk_ok ? 2'b01 : 2'b10;
`ifdef CMD_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  // Timeout fires on the idle cycle in which the gap count reaches TIMEOUT_CYCLES.
  assign timeout_hit = !rx_valid && state != S_SYNC && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else tcnt <= (rx_valid || state == S_SYNC || timeout_hit) ? '0 : tcnt + 1'b1;
`else
  assign timeout_hit = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state                <= S_SYNC;
      cmd                  <= '0;
      acc                  <= '0;
      pay0                 <= '0;
      len                  <= '0;
      idx                  <= '0;
      cmd_start            <= 1'b0;
      cmd_difficulty_valid <= 1'b0;
      difficulty           <= 1'b0;
      cmd_move_valid       <= 1'b0;
      move_dir             <= '0;
      cmd_number_valid     <= 1'b0;
      number               <= '0;
      cmd_place            <= 1'b0;
      cmd_restart          <= 1'b0;
      frame_error          <= 1'b0;
      error_code           <= '0;
      error_count          <= '0;
    end else begin
      cmd_start            <= accept && cmd == 8'h01;
      cmd_difficulty_valid <= accept && cmd == 8'h02;
      cmd_move_valid       <= accept && cmd == 8'h03;
      cmd_number_valid     <= accept && cmd == 8'h04;
      cmd_place            <= accept && cmd == 8'h05;
      cmd_restart          <= accept && cmd == 8'h06;
      frame_error          <= reject;
      if (accept && cmd == 8'h02) difficulty <= pay0[0];
      if (accept && cmd == 8'h03) move_dir <= pay0[1:0];
      if (accept && cmd == 8'h04) number <= pay0[3:0];
      if (reject) begin
        error_code  <= reject_code;
        error_count <= error_count == 8'hFF ? error_count : error_count + 8'd1;
      end
      if (timeout_hit) state <= S_SYNC;
      else if (rx_valid)
        case (state)
          S_SYNC: if (rx_data == SYNC_BYTE) begin
            state <= S_CMD;
            acc   <= '0;
          end
          S_CMD: begin
            cmd   <= rx_data;
            acc   <= acc ^ rx_data;
            state <= S_LEN;
          end
          S_LEN: if (rx_data > 8'(MAX_PAYLOAD)) state <= S_SYNC;
          else begin
            len   <= rx_data[3:0];
            acc   <= acc ^ rx_data;
            idx   <= '0;
            state <= rx_data == 8'd0 ? S_CHK : S_PAY;
          end
          // A SYNC-valued byte here is payload data, never a resync.
          S_PAY: begin
            if (idx == 4'd0) pay0 <= rx_data;
            acc   <= acc ^ rx_data;
            idx   <= idx + 4'd1;
            state <= idx == len - 4'd1 ? S_CHK : S_PAY;
          end
          S_CHK: state <= S_SYNC;
          default: state <= S_SYNC;
        endcase
    end
endmodule

// File: tb/tb_command_receiver.sv
// tb_command_receiver: directed-vector self-checking bench for command_receiver.
module tb_command_receiver;
  localparam int T = 20;
  logic       clock = 1'b0, reset_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       cmd_start, cmd_difficulty_valid, difficulty, cmd_move_valid, cmd_number_valid;
  logic       cmd_place, cmd_restart, frame_error;
  logic [1:0] move_dir, error_code;
  logic [3:0] number;
  logic [7:0] error_count;
  logic [6:0] strb;
  logic [23:0] all_out;
  int errors = 0, checks = 0;
  command_receiver #(.SYNC_BYTE(8'hAA), .MAX_PAYLOAD(4), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_start(cmd_start), .cmd_difficulty_valid(cmd_difficulty_valid), .difficulty(difficulty),
    .cmd_move_valid(cmd_move_valid), .move_dir(move_dir), .cmd_number_valid(cmd_number_valid),
    .number(number), .cmd_place(cmd_place), .cmd_restart(cmd_restart),
    .frame_error(frame_error), .error_code(error_code), .error_count(error_count));
  always #5 clock = ~clock;
  // strobe bits: start diff move num place restart ferr
  assign strb = {cmd_start, cmd_difficulty_valid, cmd_move_valid, cmd_number_valid, cmd_place, cmd_restart, frame_error};
  assign all_out = {strb, difficulty, move_dir, number, error_code, error_count};
  task automatic send(input int n, input logic [63:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      rx_data = v[8*i +: 8];
      rx_valid = 1'b1;
      @(negedge clock);
    end
  endtask
  task automatic idle(input int k);
    rx_valid = 1'b0;
    repeat (k) @(negedge clock);
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (all_out !== 24'h0) begin errors++; $display("FAIL reset_outputs: got %h want 000000", all_out); end
    reset_n = 1'b1;
    idle(2);
  endtask
  task automatic test_start;
    send(3, 64'hAA0100);
    checks++; if (strb !== 7'b0) begin errors++; $display("FAIL start_early: got %b want 0000000", strb); end
    send(1, 64'h01);
    checks++; if (strb !== 7'b1000000) begin errors++; $display("FAIL start_strobe: got %b want 1000000", strb); end
    idle(1);
    checks++; if (strb !== 7'b0) begin errors++; $display("FAIL start_one_cycle: got %b want 0000000", strb); end
  endtask
  task automatic test_back_to_back;
    send(5, 64'hAA04010702);
    checks++; if (strb !== 7'b0001000 || number !== 4'd7) begin errors++; $display("FAIL number_pkt: got %b/%0d want 0001000/7", strb, number); end
    send(5, 64'hAA03010301);
    checks++; if (strb !== 7'b0010000 || move_dir !== 2'd3 || number !== 4'd7) begin errors++; $display("FAIL b2b_move: got %b/%0d/%0d want 0010000/3/7", strb, move_dir, number); end
    idle(2);
  endtask
  task automatic test_checksum;
    send(5, 64'hAA02010103);
    checks++; if (strb !== 7'b0000001 || error_code !== 2'b01 || error_count !== 8'd1 || difficulty !== 1'b0) begin
      errors++; $display("FAIL bad_chk: got %b/%b/%0d/%b want 0000001/01/1/0", strb, error_code, error_count, difficulty); end
    idle(1);
    send(5, 64'hAA02010102);
    checks++; if (strb !== 7'b0100000 || difficulty !== 1'b1 || error_count !== 8'd1) begin
      errors++; $display("FAIL difficulty: got %b/%b/%0d want 0100000/1/1", strb, difficulty, error_count); end
    idle(1);
  endtask
  task automatic test_validation;
    send(5, 64'hAA04010A0F);
    checks++; if (strb !== 7'b0000001 || error_code !== 2'b10 || error_count !== 8'd2 || number !== 4'd7) begin
      errors++; $display("FAIL number_range: got %b/%b/%0d/%0d want 0000001/10/2/7", strb, error_code, error_count, number); end
    send(5, 64'hAA01010000);
    checks++; if (strb !== 7'b0000001 || error_code !== 2'b10 || error_count !== 8'd3) begin
      errors++; $display("FAIL start_len: got %b/%b/%0d want 0000001/10/3", strb, error_code, error_count); end
    send(8, 64'hAA02040102030402);
    checks++; if (strb !== 7'b0000001 || error_code !== 2'b10 || error_count !== 8'd4) begin
      errors++; $display("FAIL len_max: got %b/%b/%0d want 0000001/10/4", strb, error_code, error_count); end
    idle(1);
  endtask
  task automatic test_bad_len;
    send(3, 64'hAA0105);
    checks++; if (strb !== 7'b0000001 || error_code !== 2'b00 || error_count !== 8'd5) begin
      errors++; $display("FAIL bad_len: got %b/%b/%0d want 0000001/00/5", strb, error_code, error_count); end
    send(4, 64'hAA060006);
    checks++; if (strb !== 7'b0000010) begin errors++; $display("FAIL restart_after_len: got %b want 0000010", strb); end
    idle(1);
  endtask
  task automatic test_garbage;
    send(2, 64'h1355);
    checks++; if (strb !== 7'b0 || error_count !== 8'd5) begin errors++; $display("FAIL garbage: got %b/%0d want 0000000/5", strb, error_count); end
    send(4, 64'hAA050005);
    checks++; if (strb !== 7'b0000100) begin errors++; $display("FAIL place: got %b want 0000100", strb); end
    send(5, 64'hAA0301AAA8);
    checks++; if (strb !== 7'b0010000 || move_dir !== 2'd2) begin errors++; $display("FAIL sync_in_payload: got %b/%0d want 0010000/2", strb, move_dir); end
    idle(1);
  endtask
  task automatic test_saturate;
    for (int i = 0; i < 300; i++) send(3, 64'hAA0105);
    idle(1);
    checks++; if (error_count !== 8'd255) begin errors++; $display("FAIL saturate: got %0d want 255", error_count); end
  endtask
  task automatic test_timeout;
    send(2, 64'hAA01);
    rx_valid = 1'b0;
`ifdef CMD_RX_TIMEOUT_EN
    repeat (T - 1) @(negedge clock);
    checks++; if (strb !== 7'b0) begin errors++; $display("FAIL timeout_early: got %b want 0000000", strb); end
    @(negedge clock);
    checks++; if (strb !== 7'b0000001 || error_code !== 2'b11 || error_count !== 8'd255) begin
      errors++; $display("FAIL timeout: got %b/%b/%0d want 0000001/11/255", strb, error_code, error_count); end
    idle(1);
    send(4, 64'hAA060006);
    checks++; if (strb !== 7'b0000010) begin errors++; $display("FAIL restart_after_timeout: got %b want 0000010", strb); end
`else
    repeat (3 * T) @(negedge clock);
    checks++; if (strb !== 7'b0) begin errors++; $display("FAIL no_timeout: got %b want 0000000", strb); end
    send(2, 64'h0001);
    checks++; if (strb !== 7'b1000000) begin errors++; $display("FAIL late_finish: got %b want 1000000", strb); end
`endif
    idle(1);
  endtask
  task automatic test_reset_midpacket;
    send(2, 64'hAA01);
    rx_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (all_out !== 24'h0) begin errors++; $display("FAIL async_reset: got %h want 000000", all_out); end
    @(negedge clock);
    reset_n = 1'b1;
    send(2, 64'h0001);
    idle(1);
    checks++; if (all_out !== 24'h0) begin errors++; $display("FAIL dropped_packet: got %h want 000000", all_out); end
  endtask
  initial begin
    test_reset;
    test_start;
    test_back_to_back;
    test_checksum;
    test_validation;
    test_bad_len;
    test_garbage;
    test_saturate;
    test_timeout;
    test_reset_midpacket;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
